// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, queue FSM states, sizing helper.
// Used by both the transmit queue and the receive-side counterpart.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SEND,
    S_GAP
  } tx_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; storage held in flops.
// Shared by the transmit queue and the receive path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [WIDTH-1:0]       rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO may still take a byte when the head leaves that cycle.
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: FIFO plus start/busy
// handshake FSM with optional inter-frame gap and busy-rise timeout.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [UART_BYTE_W-1:0] in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   tx_start,
  output logic [UART_BYTE_W-1:0] tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic                   timeout
);

  localparam int CW = $clog2(max2(GAP_CYCLES, BUSY_WAIT) + 1);

  logic                   full;
  logic                   empty;
  logic                   pop;
  logic [UART_BYTE_W-1:0] head;

  tx_state_e              state_q;
  tx_state_e              state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   tx_start_q;
  logic                   tx_start_d;
  logic [UART_BYTE_W-1:0] tx_data_q;
  logic [UART_BYTE_W-1:0] tx_data_d;
  logic                   timeout_q;
  logic                   timeout_d;

  assign in_ready = ~full;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign timeout  = timeout_q;
  assign idle     = empty && (state_q == S_IDLE);

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid & in_ready),
    .wr_data (in_data),
    .pop     (pop),
    .flush   (flush),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .rd_data (head)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    timeout_d  = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A flushing cycle must not launch a byte it is discarding.
        if (!empty && !tx_busy && !flush) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        if (tx_busy) begin
          state_d = S_SEND;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule
